adxl357_sample_averager: RTL and testbench
==========================================

Name: adxl357_sample_averager

Overview:
- Sits directly downstream of the ADXL357 I2C controller running in HW mode.
- Detects each completed burst read via the controller's finish status bit (o_status[1]) and captures the ACCX/ACCY/ACCZ/TEMP words.
- Boxcar-averages 2^k samples per window and presents one decimated, valid-strobed frame to the packet/UART output stage.
- Also flags a stale sensor when no sample arrives within a timeout.

Parameters:
- DATA_W, 32, width of input and output sample words.
- MAX_LOG2, 8, maximum averaging exponent; accumulators are DATA_W+MAX_LOG2 bits.
- TIMEOUT_CYC, 5_000_000, i_clk cycles without a sample before o_stale asserts (100 ms at 50 MHz).
- SETTLE_CYC, 4, i_clk cycles waited after the finish falling edge before capture.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  averaging enable; low discards the window in progress.
- i_avg_log2  in  4  averaging exponent k, N = 2^k; values above MAX_LOG2 clamp to MAX_LOG2.
- i_finish  in  1  controller o_status[1]; generated in the i2c_clk domain.
- i_acc_x, i_acc_y, i_acc_z  in  DATA_W  signed, sign-extended 20-bit acceleration.
- i_temp  in  DATA_W  unsigned 12-bit temperature, zero-extended.
- o_acc_x, o_acc_y, o_acc_z  out  DATA_W  signed averaged acceleration.
- o_temp  out  DATA_W  averaged temperature.
- o_valid  out  1  one-cycle strobe; outputs are updated in the same cycle.
- o_frame_cnt  out  16  count of emitted frames; wraps 0xFFFF -> 0.
- o_stale  out  1  level; high when the timeout has expired.

Behaviour:
- Reset:
  - All outputs are 0.
  - Accumulators and sample counter are 0.
  - State is IDLE and the pending flag is clear.
- Edge detection:
  - i_finish passes through a 2-flop synchronizer.
  - A 1-to-0 transition of the synchronized signal sets the pending flag.
  - Controller output words are updated on that same i2c_clk edge.
- States:
  - IDLE:
    - Latch k = min(i_avg_log2, MAX_LOG2) and clear the accumulators and sample counter.
    - Go to WAIT when i_en = 1.
  - WAIT:
    - When pending = 1, clear pending, load the settle counter with SETTLE_CYC and go to SETTLE.
  - SETTLE: count down; at 0 go to ACCUM.
  - ACCUM:
    - Add the sign-extended i_acc_x/y/z and the zero-extended i_temp into their accumulators.
    - Increment the sample counter.
    - If the counter equals 2^k, go to EMIT; otherwise go to WAIT.
    - This state lasts exactly one cycle.
  - EMIT:
    - Each output = accumulator arithmetic-shifted right by k (floor division; temp uses a logical shift), truncated to DATA_W.
    - Pulse o_valid and increment o_frame_cnt.
    - Go to IDLE, which re-latches k for the next window.
- Latency: o_valid asserts 2 (sync) + 1 (edge) + SETTLE_CYC + 1 (ACCUM) + 1 (EMIT) cycles after i_finish falls on the last sample of the window.
- k = 0: every sample is emitted unchanged (pass-through, N = 1).
- A finish edge arriving while in SETTLE, ACCUM, EMIT or IDLE-with-i_en sets pending and is not lost. A second edge while pending is already set is dropped; samples are more than 10 µs apart, so this cannot happen in normal operation.
- i_en falling in any state:
  - Next state is IDLE, accumulators clear and pending clears.
  - No o_valid pulse.
  - Output words hold their last values.
- A change of i_avg_log2 mid-window has no effect until the next IDLE.
- Watchdog:
  - A 23-bit counter clears on every capture (ACCUM) and while i_en = 0; otherwise it increments and saturates.
  - o_stale = 1 when counter >= TIMEOUT_CYC; it clears on the cycle after the next capture.
- Accumulator overflow is impossible: 20-bit data plus 8 bits of growth fits in DATA_W+MAX_LOG2.
- i_rst asserted mid-window: full reset in the next cycle; no partial frame is emitted.

Decomposition:
- Package adxl357_pkg:
  - enum avg_state_t {IDLE, WAIT, SETTLE, ACCUM, EMIT}.
  - ACC_DATA_W = 20 and TEMP_DATA_W = 12.
  - Default TIMEOUT_CYC.
  - The clamp function for k.
- Sub-module adxl357_finish_edge_det: 2-flop synchronizer plus falling-edge pulse output, reused by the other sensor-controller consumers.

Test Plan:
- k=0, i_en=1; one sample X=-5, Y=3, Z=0x7FFFF, T=0x9A0 -> one o_valid with the same values, frame_cnt=1, exactly 9 cycles after the synchronized fall (SETTLE_CYC=4).
- k=2; X samples {4, -3, 7, -1} -> o_acc_x = 7>>2 = 1; four samples of X=-1 -> o_acc_x = -1 (floor); exactly one o_valid per 4 finish pulses.
- k=2; drop i_en after 2 samples, then re-enable and feed 4 samples of X=8 -> no valid during the abort; next frame X=8, not polluted by the earlier samples.
- i_avg_log2=12 -> clamps to 8; 256 samples of Z=0x7FFFF produce 0x7FFFF with no overflow; the 255th sample produces no valid.
- TIMEOUT_CYC=100, i_en=1, no finish for 100 cycles -> o_stale=1; one sample -> o_stale=0 next cycle.
- Assert i_rst during SETTLE of the 3rd sample (k=2) -> all outputs 0, state IDLE, no o_valid; frame_cnt wrap verified by forcing 0xFFFF -> 0.

Source files
------------

// File: rtl/adxl357_pkg.sv
// Shared types and constants for the ADXL357 sample-averaging path.
package adxl357_pkg;

    localparam int ACC_DATA_W          = 20;
    localparam int TEMP_DATA_W         = 12;
    localparam int DEFAULT_TIMEOUT_CYC = 5_000_000;
    localparam int WD_W                = 23;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETTLE = 3'd2,
        ACCUM  = 3'd3,
        EMIT   = 3'd4
    } avg_state_t;

    // Requested averaging exponent limited to what the accumulators can hold.
    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/adxl357_finish_edge_det.sv
// Brings the controller finish bit into i_clk and flags its falling edge.
module adxl357_finish_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_finish,
    output logic o_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_finish;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // One-cycle pulse on the first cycle the synchronized level reads low.
    assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/adxl357_sample_averager.sv
// Captures each completed ADXL357 burst, boxcar-averages 2^k samples and
// emits one decimated frame; also raises o_stale when samples stop arriving.
module adxl357_sample_averager
    import adxl357_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_LOG2    = 8,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int SETTLE_CYC  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [3:0]        i_avg_log2,
    input  logic              i_finish,
    input  logic [DATA_W-1:0] i_acc_x,
    input  logic [DATA_W-1:0] i_acc_y,
    input  logic [DATA_W-1:0] i_acc_z,
    input  logic [DATA_W-1:0] i_temp,
    output logic [DATA_W-1:0] o_acc_x,
    output logic [DATA_W-1:0] o_acc_y,
    output logic [DATA_W-1:0] o_acc_z,
    output logic [DATA_W-1:0] o_temp,
    output logic              o_valid,
    output logic [15:0]       o_frame_cnt,
    output logic              o_stale,
    output avg_state_t        o_state
);

    localparam int AW = DATA_W + MAX_LOG2;
    localparam int CW = MAX_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_CYC + 2);
    localparam logic [3:0]      MAX_K       = 4'(MAX_LOG2);
    localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC);
    localparam logic [WD_W-1:0] TIMEOUT_LIM = WD_W'(TIMEOUT_CYC);

    avg_state_t             state_q;
    logic [3:0]             k_q;
    logic [CW-1:0]          sample_cnt_q;
    logic [SW-1:0]          settle_cnt_q;
    logic                   pending_q;
    logic signed [AW-1:0]   acc_x_q;
    logic signed [AW-1:0]   acc_y_q;
    logic signed [AW-1:0]   acc_z_q;
    logic [AW-1:0]          acc_t_q;
    logic [WD_W-1:0]        wd_cnt_q;

    logic                   fin_fall;
    logic signed [AW-1:0]   ext_x;
    logic signed [AW-1:0]   ext_y;
    logic signed [AW-1:0]   ext_z;
    logic [AW-1:0]          ext_t;
    logic [CW-1:0]          sample_cnt_nx;
    logic [CW-1:0]          win_len;

    adxl357_finish_edge_det u_finish_edge (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_finish (i_finish),
        .o_fall   (fin_fall)
    );

    assign ext_x         = {{MAX_LOG2{i_acc_x[DATA_W-1]}}, i_acc_x};
    assign ext_y         = {{MAX_LOG2{i_acc_y[DATA_W-1]}}, i_acc_y};
    assign ext_z         = {{MAX_LOG2{i_acc_z[DATA_W-1]}}, i_acc_z};
    assign ext_t         = {{MAX_LOG2{1'b0}}, i_temp};
    assign sample_cnt_nx = sample_cnt_q + CW'(1);
    assign win_len       = CW'(1) << k_q;

    // o_valid is a one-cycle strobe with no back-pressure: the output words
    // change in the same cycle and the consumer must take them then.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            pending_q    <= 1'b0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            acc_z_q      <= '0;
            acc_t_q      <= '0;
            o_acc_x      <= '0;
            o_acc_y      <= '0;
            o_acc_z      <= '0;
            o_temp       <= '0;
            o_valid      <= 1'b0;
            o_frame_cnt  <= '0;
        end else if (!i_en) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            pending_q    <= 1'b0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            acc_z_q      <= '0;
            acc_t_q      <= '0;
            o_valid      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            // Edges outside WAIT are remembered; a second one while pending is dropped.
            if (fin_fall && state_q != WAIT) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    k_q          <= clamp_log2(i_avg_log2, MAX_K);
                    sample_cnt_q <= '0;
                    acc_x_q      <= '0;
                    acc_y_q      <= '0;
                    acc_z_q      <= '0;
                    acc_t_q      <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (pending_q || fin_fall) begin
                        pending_q    <= 1'b0;
                        settle_cnt_q <= SETTLE_LOAD;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - SW'(1);
                    end
                    if (settle_cnt_q <= SW'(1)) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_x_q      <= acc_x_q + ext_x;
                    acc_y_q      <= acc_y_q + ext_y;
                    acc_z_q      <= acc_z_q + ext_z;
                    acc_t_q      <= acc_t_q + ext_t;
                    sample_cnt_q <= sample_cnt_nx;
                    state_q      <= (sample_cnt_nx == win_len) ? EMIT : WAIT;
                end
                EMIT: begin
                    // Arithmetic shift floors signed averages toward -inf.
                    o_acc_x     <= DATA_W'(acc_x_q >>> k_q);
                    o_acc_y     <= DATA_W'(acc_y_q >>> k_q);
                    o_acc_z     <= DATA_W'(acc_z_q >>> k_q);
                    o_temp      <= DATA_W'(acc_t_q >> k_q);
                    o_valid     <= 1'b1;
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en || state_q == ACCUM) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != {WD_W{1'b1}}) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
    end

    assign o_stale = (wd_cnt_q >= TIMEOUT_LIM);
    assign o_state = state_q;

endmodule

// File: tb/tb_adxl357_sample_averager.sv
// Randomized bench for the ADXL357 averager against an arithmetic window model.
module tb_adxl357_sample_averager;
    import adxl357_pkg::*;

    logic        clk;
    logic        i_rst;
    logic        i_en;
    logic [3:0]  i_avg_log2;
    logic        i_finish;
    logic [31:0] i_acc_x, i_acc_y, i_acc_z, i_temp;
    logic [31:0] o_acc_x, o_acc_y, o_acc_z, o_temp;
    logic        o_valid;
    logic [15:0] o_frame_cnt;
    logic        o_stale;
    avg_state_t  o_state;

    adxl357_sample_averager #(
        .DATA_W(32), .MAX_LOG2(8), .TIMEOUT_CYC(100), .SETTLE_CYC(4)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_avg_log2(i_avg_log2),
        .i_finish(i_finish), .i_acc_x(i_acc_x), .i_acc_y(i_acc_y),
        .i_acc_z(i_acc_z), .i_temp(i_temp), .o_acc_x(o_acc_x),
        .o_acc_y(o_acc_y), .o_acc_z(o_acc_z), .o_temp(o_temp),
        .o_valid(o_valid), .o_frame_cnt(o_frame_cnt), .o_stale(o_stale),
        .o_state(o_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [15:0] obs_fc_q[$];
    int          valid_cnt = 0;
    int          last_valid_cyc = 0;
    int          fall_cyc = 0;
    int          total = 0;
    int          bad = 0;

    longint      win_x[$], win_y[$], win_z[$], win_t[$];
    int          model_k = 0;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            obs_q.push_back(o_acc_x);
            obs_q.push_back(o_acc_y);
            obs_q.push_back(o_acc_z);
            obs_q.push_back(o_temp);
            obs_fc_q.push_back(o_frame_cnt);
            valid_cnt++;
            last_valid_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] floor_avg(longint s, int k);
        longint n;
        longint q;
        n = longint'(1) << k;
        if (s >= 0) q = s / n;
        else        q = -((-s + n - 1) / n);
        return q[31:0];
    endfunction

    function automatic int rnd20();
        int v;
        v = int'($urandom_range(0, 1048575));
        if (v >= 524288) v -= 1048576;
        return v;
    endfunction

    task automatic model_push(int x, int y, int z, int t);
        longint sx, sy, sz, st;
        win_x.push_back(x); win_y.push_back(y);
        win_z.push_back(z); win_t.push_back(t);
        if (win_x.size() == (1 << model_k)) begin
            sx = 0; sy = 0; sz = 0; st = 0;
            foreach (win_x[i]) begin
                sx += win_x[i]; sy += win_y[i]; sz += win_z[i]; st += win_t[i];
            end
            exp_q.push_back(floor_avg(sx, model_k));
            exp_q.push_back(floor_avg(sy, model_k));
            exp_q.push_back(floor_avg(sz, model_k));
            st = st / (longint'(1) << model_k);
            exp_q.push_back(st[31:0]);
            win_x.delete(); win_y.delete(); win_z.delete(); win_t.delete();
        end
    endtask

    task automatic model_abort();
        win_x.delete(); win_y.delete(); win_z.delete(); win_t.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic set_mode(int k);
        @(negedge clk);
        i_en = 1'b0;
        repeat (2) @(negedge clk);
        i_avg_log2 = 4'(k);
        i_en = 1'b1;
        model_k = (k > 8) ? 8 : k;
        model_abort();
        exp_q.delete(); obs_q.delete(); obs_fc_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Raise finish, then drop it together with new words, like a burst end.
    task automatic start_sample(int x, int y, int z, int t);
        @(negedge clk);
        i_finish = 1'b1;
        repeat (3) @(negedge clk);
        i_acc_x = x; i_acc_y = y; i_acc_z = z; i_temp = t;
        i_finish = 1'b0;
        fall_cyc = cyc;
        if (i_en) model_push(x, y, z, t);
    endtask

    task automatic send_sample(int x, int y, int z, int t);
        start_sample(x, y, z, t);
        repeat (14) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_en = 1'b0; i_avg_log2 = 4'd0; i_finish = 1'b0;
        i_acc_x = '0; i_acc_y = '0; i_acc_z = '0; i_temp = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        total++; if (o_acc_x !== 32'd0) begin bad++; $display("FAIL reset_x got=%h want=0", o_acc_x); end
        total++; if (o_acc_y !== 32'd0) begin bad++; $display("FAIL reset_y got=%h want=0", o_acc_y); end
        total++; if (o_acc_z !== 32'd0) begin bad++; $display("FAIL reset_z got=%h want=0", o_acc_z); end
        total++; if (o_temp !== 32'd0) begin bad++; $display("FAIL reset_t got=%h want=0", o_temp); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_fc got=%h want=0", o_frame_cnt); end
        total++; if (o_stale !== 1'b0) begin bad++; $display("FAIL reset_stale got=%b want=0", o_stale); end
        total++; if (o_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", o_state, IDLE); end
    endtask

    task automatic test_passthrough();
        int v0;
        logic [31:0] lit[4];
        logic [31:0] ow, ew;
        lit[0] = 32'hFFFF_FFFB; lit[1] = 32'd3; lit[2] = 32'h0007_FFFF; lit[3] = 32'h0000_09A0;
        set_mode(0);
        v0 = valid_cnt;
        send_sample(-5, 3, 'h7FFFF, 'h9A0);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL pass_count got=%0d want=1", valid_cnt - v0); end
        total++; if (last_valid_cyc - fall_cyc != 9) begin bad++; $display("FAIL pass_latency got=%0d want=9", last_valid_cyc - fall_cyc); end
        total++; if (o_frame_cnt !== 16'd1) begin bad++; $display("FAIL pass_fc got=%0d want=1", o_frame_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL pass_word%0d missing want=%h", i, lit[i]); end
            else begin
                ow = obs_q.pop_front();
                if (ow !== lit[i]) begin bad++; $display("FAIL pass_word%0d got=%h want=%h", i, ow, lit[i]); end
            end
        end
        exp_q.delete();
        for (int s = 0; s < 4; s++) send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL pass_rand missing want=%h", ew); end
            else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin bad++; $display("FAIL pass_rand got=%h want=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_average();
        int xs[4];
        int v0;
        logic [31:0] ow, ew;
        xs[0] = 4; xs[1] = -3; xs[2] = 7; xs[3] = -1;
        set_mode(2);
        v0 = valid_cnt;
        for (int s = 0; s < 3; s++) send_sample(xs[s], rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL avg_early got=%0d want=0", valid_cnt - v0); end
        send_sample(xs[3], rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        for (int s = 0; s < 4; s++) send_sample(-1, rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        total++; if (valid_cnt - v0 != 2) begin bad++; $display("FAIL avg_count got=%0d want=2", valid_cnt - v0); end
        total++; if (obs_q.size() == 8 && obs_q[0] !== 32'd1) begin bad++; $display("FAIL avg_x_pos got=%h want=1", obs_q[0]); end
        total++; if (obs_q.size() == 8 && obs_q[4] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL avg_x_floor got=%h want=ffffffff", obs_q[4]); end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL avg_word missing want=%h", ew); end
            else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin bad++; $display("FAIL avg_word got=%h want=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_abort();
        int v0;
        logic [31:0] ow, ew;
        set_mode(2);
        for (int s = 0; s < 4; s++) send_sample(20, -20, 0, 40);
        for (int s = 0; s < 2; s++) send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        v0 = valid_cnt;
        @(negedge clk);
        i_en = 1'b0;
        model_abort();
        repeat (3) @(negedge clk);
        total++; if (o_state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d want=%0d", o_state, IDLE); end
        total++; if (o_acc_x !== 32'd20) begin bad++; $display("FAIL abort_hold_x got=%h want=14", o_acc_x); end
        total++; if (o_temp !== 32'd40) begin bad++; $display("FAIL abort_hold_t got=%h want=28", o_temp); end
        i_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) send_sample(8, -8, 100, 12);
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL abort_count got=%0d want=1", valid_cnt - v0); end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL abort_word missing want=%h", ew); end
            else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin bad++; $display("FAIL abort_word got=%h want=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_clamp();
        int v0;
        logic [31:0] ow, ew;
        set_mode(12);
        v0 = valid_cnt;
        for (int s = 0; s < 255; s++) send_sample(rnd20(), rnd20(), 'h7FFFF, int'($urandom_range(0, 4095)));
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL clamp_255 got=%0d want=0", valid_cnt - v0); end
        send_sample(rnd20(), rnd20(), 'h7FFFF, int'($urandom_range(0, 4095)));
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL clamp_256 got=%0d want=1", valid_cnt - v0); end
        total++; if (o_acc_z !== 32'h0007_FFFF) begin bad++; $display("FAIL clamp_z got=%h want=7ffff", o_acc_z); end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL clamp_word missing want=%h", ew); end
            else begin
                ow = obs_q.pop_front();
                if (ow !== ew) begin bad++; $display("FAIL clamp_word got=%h want=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [31:0] ow, ew;
        for (int w = 0; w < 4; w++) begin
            k = int'($urandom_range(0, 3));
            set_mode(k);
            for (int s = 0; s < 2 * (1 << k); s++)
                send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(0, 4095)));
            total++; if (obs_q.size() != 8) begin bad++; $display("FAIL b2b_frames k=%0d got=%0d want=2", k, obs_q.size() / 4); end
            while (exp_q.size() > 0) begin
                ew = exp_q.pop_front();
                total++;
                if (obs_q.size() == 0) begin bad++; $display("FAIL b2b_word missing want=%h", ew); end
                else begin
                    ow = obs_q.pop_front();
                    if (ow !== ew) begin bad++; $display("FAIL b2b_word k=%0d got=%h want=%h", k, ow, ew); end
                end
            end
        end
    endtask

    task automatic test_stale();
        @(negedge clk);
        i_en = 1'b0;
        i_avg_log2 = 4'd0;
        model_k = 0;
        model_abort();
        repeat (2) @(negedge clk);
        i_en = 1'b1;
        repeat (99) @(negedge clk);
        total++; if (o_stale !== 1'b0) begin bad++; $display("FAIL stale_early got=%b want=0", o_stale); end
        @(negedge clk);
        total++; if (o_stale !== 1'b1) begin bad++; $display("FAIL stale_set got=%b want=1", o_stale); end
        start_sample(-100, 50, 7, 300);
        repeat (7) @(negedge clk);
        total++; if (o_state !== ACCUM) begin bad++; $display("FAIL stale_accum_state got=%0d want=%0d", o_state, ACCUM); end
        total++; if (o_stale !== 1'b1) begin bad++; $display("FAIL stale_hold got=%b want=1", o_stale); end
        @(negedge clk);
        total++; if (o_stale !== 1'b0) begin bad++; $display("FAIL stale_clear got=%b want=0", o_stale); end
        repeat (8) @(negedge clk);
        total++; if (o_acc_x !== 32'hFFFF_FF9C) begin bad++; $display("FAIL stale_frame_x got=%h want=ffffff9c", o_acc_x); end
    endtask

    task automatic test_reset_mid();
        int v0;
        set_mode(2);
        for (int s = 0; s < 2; s++) send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(1, 4095)));
        start_sample(rnd20(), rnd20(), rnd20(), 5);
        repeat (4) @(negedge clk);
        total++; if (o_state !== SETTLE) begin bad++; $display("FAIL mid_settle got=%0d want=%0d", o_state, SETTLE); end
        i_rst = 1'b1;
        @(negedge clk);
        total++; if (o_state !== IDLE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", o_state, IDLE); end
        total++; if (o_acc_x !== 32'd0 || o_acc_y !== 32'd0 || o_acc_z !== 32'd0 || o_temp !== 32'd0) begin
            bad++; $display("FAIL mid_outputs got=%h %h %h %h want=0", o_acc_x, o_acc_y, o_acc_z, o_temp);
        end
        total++; if (o_frame_cnt !== 16'd0) begin bad++; $display("FAIL mid_fc got=%0d want=0", o_frame_cnt); end
        i_rst = 1'b0;
        v0 = valid_cnt;
        repeat (20) @(negedge clk);
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", valid_cnt - v0); end
    endtask

    task automatic test_wrap();
        set_mode(0);
        @(negedge clk);
        force dut.o_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.o_frame_cnt;
        send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        total++; if (obs_fc_q.size() != 1 || obs_fc_q[0] !== 16'd0) begin bad++; $display("FAIL wrap_zero got_frames=%0d fc=%h want=0", obs_fc_q.size(), o_frame_cnt); end
        send_sample(rnd20(), rnd20(), rnd20(), int'($urandom_range(0, 4095)));
        total++; if (o_frame_cnt !== 16'd1) begin bad++; $display("FAIL wrap_one got=%h want=1", o_frame_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_passthrough();
        test_average();
        test_abort();
        test_clamp();
        test_back_to_back();
        test_stale();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d limit=100000", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
